// File: rtl/emu_scan_pkg.sv
// ============================================================================
// emu_scan_pkg : shared sizes and types for the scan-instrumented RAM
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package emu_scan_pkg;

  localparam int DATA_WIDTH = 80;
  localparam int ADDR_WIDTH = 3;
  localparam int SCAN_WIDTH = 64;
  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int FF_WORDS   = (DATA_WIDTH + SCAN_WIDTH - 1) / SCAN_WIDTH;
  localparam int MEM_WORDS  = DEPTH * FF_WORDS;
  localparam int HI_WIDTH   = DATA_WIDTH - SCAN_WIDTH;
  localparam int PAD_WIDTH  = SCAN_WIDTH - HI_WIDTH;
  localparam int CNT_WIDTH  = $clog2(MEM_WORDS + 2);

  typedef logic [SCAN_WIDTH-1:0] scan_word_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [CNT_WIDTH-1:0]  cnt_t;

  localparam cnt_t CNT_WORDS = cnt_t'(MEM_WORDS);
  localparam cnt_t CNT_MAX   = cnt_t'(MEM_WORDS + 1);

endpackage

`default_nettype wire

// File: rtl/emu_ram_scan_ctrl.sv
// ============================================================================
// emu_ram_scan_ctrl : RAM scan sequencer (word counter, dump register, load buffer)
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module emu_ram_scan_ctrl
  import emu_scan_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       se,
  input  logic       sd,
  input  scan_word_t di,
  input  data_t      rd_data,
  output addr_t      rd_addr,
  output logic       wr_en,
  output addr_t      wr_addr,
  output data_t      wr_data,
  output scan_word_t ram_do
);

  cnt_t                  cnt_q, cnt_d;
  scan_word_t            do_q, do_d;
  scan_word_t            lo_q, lo_d;
  logic [ADDR_WIDTH:0]   dump_idx;

  // A dump word is fetched one edge after the counter points at it, hence cnt-1.
  always_comb begin
    cnt_d    = cnt_q;
    do_d     = do_q;
    lo_d     = lo_q;
    wr_en    = 1'b0;
    dump_idx = cnt_q[ADDR_WIDTH:0] - 1'b1;
    rd_addr  = dump_idx[ADDR_WIDTH:1];
    wr_addr  = cnt_q[ADDR_WIDTH:1];
    wr_data  = {di[HI_WIDTH-1:0], lo_q};
    if (!se) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      if (!sd) begin
        if (cnt_q != '0 && cnt_q <= CNT_WORDS)
          do_d = dump_idx[0] ? {{PAD_WIDTH{1'b0}}, rd_data[DATA_WIDTH-1:SCAN_WIDTH]}
                             : rd_data[SCAN_WIDTH-1:0];
      end else if (cnt_q < CNT_WORDS) begin
        if (cnt_q[0]) wr_en = 1'b1;
        else          lo_d  = di;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      do_q  <= '0;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      do_q  <= do_d;
      lo_q  <= lo_d;
    end
  end

  assign ram_do = do_q;

endmodule

`default_nettype wire

// File: rtl/emu_scan_srsw_ram.sv
// ============================================================================
// emu_scan_srsw_ram : 8x80 SRSW RAM with FF scan over rdata and RAM scan port
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module emu_scan_srsw_ram
  import emu_scan_pkg::*;
(
  input  logic                  emu_host_clk,
  input  logic                  emu_dut_rst_n,
  input  logic                  emu_ff_clk_en,
  input  logic                  emu_ram_clk_en,
  input  logic                  emu_ff_se,
  input  logic [SCAN_WIDTH-1:0] emu_ff_di,
  output logic [SCAN_WIDTH-1:0] emu_ff_do,
  input  logic                  emu_ram_se,
  input  logic                  emu_ram_sd,
  input  logic [SCAN_WIDTH-1:0] emu_ram_di,
  output logic [SCAN_WIDTH-1:0] emu_ram_do,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata
);

  data_t                 mem_q [DEPTH];
  data_t                 mem_d [DEPTH];
  data_t                 rdata_q, rdata_d;
  // Upper bits of chain word1; they carry a full 64-bit word across a two-shift pass.
  logic [PAD_WIDTH-1:0]  ff_pad_q, ff_pad_d;
  addr_t                 scan_rd_addr;
  logic                  scan_wr_en;
  addr_t                 scan_wr_addr;
  data_t                 scan_wr_data;

  emu_ram_scan_ctrl u_scan_ctrl (
    .clk     (emu_host_clk),
    .rst_n   (emu_dut_rst_n),
    .en      (emu_ram_clk_en),
    .se      (emu_ram_se),
    .sd      (emu_ram_sd),
    .di      (emu_ram_di),
    .rd_data (mem_q[scan_rd_addr]),
    .rd_addr (scan_rd_addr),
    .wr_en   (scan_wr_en),
    .wr_addr (scan_wr_addr),
    .wr_data (scan_wr_data),
    .ram_do  (emu_ram_do)
  );

  always_comb begin
    rdata_d  = rdata_q;
    ff_pad_d = ff_pad_q;
    if (emu_ff_clk_en) begin
      if (emu_ff_se) begin
        rdata_d  = {emu_ff_di[HI_WIDTH-1:0], ff_pad_q, rdata_q[DATA_WIDTH-1:SCAN_WIDTH]};
        ff_pad_d = emu_ff_di[SCAN_WIDTH-1:HI_WIDTH];
      end else begin
        rdata_d  = mem_q[raddr];
        ff_pad_d = '0;
      end
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (emu_ram_clk_en) begin
      if (emu_ram_se) begin
        if (scan_wr_en) mem_d[scan_wr_addr] = scan_wr_data;
      end else if (wen) begin
        mem_d[waddr] = wdata;
      end
    end
  end

  always_ff @(posedge emu_host_clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge emu_host_clk or negedge emu_dut_rst_n) begin
    if (!emu_dut_rst_n) begin
      rdata_q  <= '0;
      ff_pad_q <= '0;
    end else begin
      rdata_q  <= rdata_d;
      ff_pad_q <= ff_pad_d;
    end
  end

  assign rdata     = rdata_q;
  assign emu_ff_do = rdata_q[SCAN_WIDTH-1:0];

endmodule

`default_nettype wire

// File: tb/tb_emu_scan_srsw_ram.sv
// ============================================================================
// tb_emu_scan_srsw_ram : directed self-checking bench for emu_scan_srsw_ram
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_emu_scan_srsw_ram;
  import emu_scan_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ff_en, ram_en, ff_se, ram_se, ram_sd, wen;
  logic [63:0] ff_di, ff_do, ram_di, ram_do;
  logic [2:0]  raddr, waddr;
  logic [79:0] rdata, wdata;

  always #5 clk = ~clk;

  emu_scan_srsw_ram dut (
    .emu_host_clk   (clk),
    .emu_dut_rst_n  (rst_n),
    .emu_ff_clk_en  (ff_en),
    .emu_ram_clk_en (ram_en),
    .emu_ff_se      (ff_se),
    .emu_ff_di      (ff_di),
    .emu_ff_do      (ff_do),
    .emu_ram_se     (ram_se),
    .emu_ram_sd     (ram_sd),
    .emu_ram_di     (ram_di),
    .emu_ram_do     (ram_do),
    .raddr          (raddr),
    .rdata          (rdata),
    .wen            (wen),
    .waddr          (waddr),
    .wdata          (wdata)
  );

  typedef struct {
    logic        ff_en;
    logic        ram_en;
    logic        wen;
    logic [2:0]  waddr;
    logic [79:0] wdata;
    logic [2:0]  raddr;
    logic        chk;
    logic [79:0] exp;
  } vec_t;

  vec_t        vecs [16];
  int          checks   = 0;
  int          failures = 0;
  logic [79:0] model     [8];
  logic [79:0] saved_mem [4][8];
  logic [79:0] saved_rd  [4];
  logic [79:0] hold;
  logic [2:0]  ra;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [79:0] pat(input logic [15:0] tag, input int i);
    return {tag + 16'(i), 64'h1111_2222_3333_0000 + 64'(i)};
  endfunction

  function automatic logic [63:0] word_of(input logic [79:0] e, input int odd);
    return (odd != 0) ? {48'b0, e[79:64]} : e[63:0];
  endfunction

  function automatic logic [79:0] rnd80();
    return {16'($urandom()), $urandom(), $urandom()};
  endfunction

  task automatic vset(input int n, input logic fe, input logic re, input logic we,
                      input logic [2:0] wa, input logic [79:0] wd, input logic [2:0] rda,
                      input logic c, input logic [79:0] e);
    vecs[n] = '{ff_en: fe, ram_en: re, wen: we, waddr: wa, wdata: wd,
                raddr: rda, chk: c, exp: e};
  endtask

  initial begin
    // Functional table: writes, pipelined reads, read-first collision, per-domain pause.
    vset(0,  1, 1, 1, 3'd0, pat(16'hA0A0, 0), 3'd0, 0, '0);
    vset(1,  1, 1, 1, 3'd1, pat(16'hA0A0, 1), 3'd0, 1, pat(16'hA0A0, 0));
    vset(2,  1, 1, 1, 3'd2, pat(16'hA0A0, 2), 3'd1, 1, pat(16'hA0A0, 1));
    vset(3,  1, 1, 1, 3'd3, pat(16'hA0A0, 3), 3'd2, 1, pat(16'hA0A0, 2));
    vset(4,  1, 1, 1, 3'd4, pat(16'hA0A0, 4), 3'd3, 1, pat(16'hA0A0, 3));
    vset(5,  1, 1, 1, 3'd5, pat(16'hA0A0, 5), 3'd4, 1, pat(16'hA0A0, 4));
    vset(6,  1, 1, 1, 3'd6, pat(16'hA0A0, 6), 3'd5, 1, pat(16'hA0A0, 5));
    vset(7,  1, 1, 1, 3'd7, pat(16'hA0A0, 7), 3'd6, 1, pat(16'hA0A0, 6));
    vset(8,  1, 1, 0, 3'd0, '0,               3'd7, 1, pat(16'hA0A0, 7));
    vset(9,  1, 1, 1, 3'd3, pat(16'hB0B0, 3), 3'd3, 1, pat(16'hA0A0, 3));
    vset(10, 1, 1, 0, 3'd0, '0,               3'd3, 1, pat(16'hB0B0, 3));
    vset(11, 0, 1, 0, 3'd0, '0,               3'd0, 1, pat(16'hB0B0, 3));
    vset(12, 1, 0, 1, 3'd4, pat(16'hB0B0, 4), 3'd4, 1, pat(16'hA0A0, 4));
    vset(13, 1, 1, 0, 3'd0, '0,               3'd4, 1, pat(16'hA0A0, 4));
    vset(14, 1, 1, 1, 3'd0, pat(16'hB0B0, 0), 3'd0, 1, pat(16'hA0A0, 0));
    vset(15, 1, 1, 0, 3'd0, '0,               3'd0, 1, pat(16'hB0B0, 0));

    rst_n = 1'b0; ff_en = 1'b0; ram_en = 1'b0; ff_se = 1'b0; ram_se = 1'b0;
    ram_sd = 1'b0; wen = 1'b0; ff_di = '0; ram_di = '0; raddr = '0; waddr = '0; wdata = '0;
    #12;
    chk("reset_rdata", rdata, '0);
    chk("reset_ff_do", 80'(ff_do), '0);
    chk("reset_ram_do", 80'(ram_do), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int n = 0; n < 16; n++) begin
      ff_en = vecs[n].ff_en; ram_en = vecs[n].ram_en; wen = vecs[n].wen;
      waddr = vecs[n].waddr; wdata = vecs[n].wdata; raddr = vecs[n].raddr;
      step();
      if (vecs[n].chk) chk($sformatf("vec%0d_rdata", n), rdata, vecs[n].exp);
    end
    wen = 1'b0;

    // Four save rounds: fresh data, FF scan loop, RAM dump.
    for (int r = 0; r < 4; r++) begin
      ff_en = 1'b1; ram_en = 1'b1; wen = 1'b1;
      for (int i = 0; i < 8; i++) begin
        waddr = 3'(i); wdata = rnd80(); model[i] = wdata; step();
      end
      wen = 1'b0;
      ra = 3'((r * 3 + 1) % 8);
      raddr = ra; step();
      chk($sformatf("r%0d_read", r), rdata, model[ra]);
      saved_rd[r] = model[ra];
      for (int i = 0; i < 8; i++) saved_mem[r][i] = model[i];

      ff_en = 1'b0; ram_en = 1'b0; raddr = ra + 3'd1; step();
      chk($sformatf("r%0d_pause_hold", r), rdata, saved_rd[r]);

      ff_se = 1'b1; ff_en = 1'b1;
      chk($sformatf("r%0d_ff_w0", r), 80'(ff_do), 80'(saved_rd[r][63:0]));
      ff_di = ff_do; step();
      chk($sformatf("r%0d_ff_w1", r), 80'(ff_do), 80'(word_of(saved_rd[r], 1)));
      ff_di = ff_do; step();
      ff_se = 1'b0; ff_en = 1'b0;
      chk($sformatf("r%0d_ff_loop", r), rdata, saved_rd[r]);

      ram_se = 1'b1; ram_sd = 1'b0; ram_en = 1'b1;
      for (int e = 1; e <= 18; e++) begin
        step();
        if (e >= 2 && e <= 17)
          chk($sformatf("r%0d_dump%0d", r, e - 2), 80'(ram_do),
              80'(word_of(model[(e - 2) / 2], (e - 2) % 2)));
      end
      ram_se = 1'b0; ram_en = 1'b0; step();
      chk($sformatf("r%0d_dump_rdata", r), rdata, saved_rd[r]);
    end

    // Overwrite everything before restoring.
    ff_en = 1'b1; ram_en = 1'b1; wen = 1'b1;
    for (int i = 0; i < 8; i++) begin
      waddr = 3'(i); wdata = rnd80(); model[i] = wdata; step();
    end
    wen = 1'b0; raddr = 3'd0; step();
    chk("overwrite_read", rdata, model[0]);

    for (int r = 0; r < 4; r++) begin
      ff_en = 1'b0; ram_en = 1'b0; step();
      ff_se = 1'b1; ff_en = 1'b1;
      ff_di = saved_rd[r][63:0]; step();
      ff_di = {48'($urandom()) | 48'h1, saved_rd[r][79:64]}; step();
      ff_se = 1'b0; ff_en = 1'b0;

      ram_se = 1'b1; ram_sd = 1'b1; ram_en = 1'b1;
      for (int j = 0; j < 16; j++) begin
        ram_di = word_of(saved_mem[r][j / 2], j % 2); step();
      end
      ram_di = {$urandom(), $urandom()}; step();
      ram_se = 1'b0; ram_sd = 1'b0; ram_en = 1'b0; ram_di = '0; step();
      chk($sformatf("r%0d_restore_rdata", r), rdata, saved_rd[r]);

      ff_en = 1'b1; ram_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
        raddr = 3'(i); step();
        chk($sformatf("r%0d_restore_mem%0d", r, i), rdata, saved_mem[r][i]);
        model[i] = saved_mem[r][i];
      end
    end

    // Same-address read/write collision.
    hold = rnd80();
    wen = 1'b1; waddr = 3'd3; raddr = 3'd3; wdata = hold; step();
    chk("collide_old", rdata, model[3]);
    model[3] = hold; wen = 1'b0; step();
    chk("collide_new", rdata, hold);

    // Reset in the middle of a dump.
    ff_en = 1'b0; ram_se = 1'b1; ram_sd = 1'b0; ram_en = 1'b1;
    for (int e = 1; e <= 5; e++) step();
    chk("pre_rst_dump3", 80'(ram_do), 80'(word_of(model[1], 1)));
    rst_n = 1'b0; #1;
    chk("mid_rst_rdata", rdata, '0);
    chk("mid_rst_ram_do", 80'(ram_do), '0);
    chk("mid_rst_ff_do", 80'(ff_do), '0);
    step();
    rst_n = 1'b1;
    step(); step();
    chk("post_rst_dump0", 80'(ram_do), 80'(word_of(model[0], 0)));
    step();
    chk("post_rst_dump1", 80'(ram_do), 80'(word_of(model[0], 1)));
    ram_se = 1'b0; ff_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      raddr = 3'(i); step();
      chk($sformatf("post_rst_mem%0d", i), rdata, model[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/emu_scan_srsw_ram.md
Name: emu_scan_srsw_ram

Overview:
- Emulation-instrumented single-read/single-write RAM: 8 x 80-bit array plus an 80-bit registered read port.
- Instrumented for checkpoint/restore:
  - flip-flop scan chain over the read-data register;
  - RAM scan port that dumps or loads the whole array as 64-bit words.
- Sits inside the emulated DUT. The host pauses it through two clock-enable inputs, which replace gated clocks.

Parameters:
- DATA_WIDTH, 80, memory word and rdata width
- ADDR_WIDTH, 3, address width (DEPTH = 8)
- SCAN_WIDTH, 64, scan word width
- FF_WORDS, 2, derived: ceil(DATA_WIDTH/SCAN_WIDTH)
- MEM_WORDS, 16, derived: DEPTH*FF_WORDS

Ports:
- emu_host_clk  in  1  sole clock, rising edge
- emu_dut_rst_n  in  1  asynchronous active-low reset
- emu_ff_clk_en  in  1  enable for flip-flop domain (host drives !pause | ff_se)
- emu_ram_clk_en  in  1  enable for RAM domain (host drives !pause | ram_se)
- emu_ff_se  in  1  FF scan enable
- emu_ff_di  in  64  FF scan input word
- emu_ff_do  out  64  FF scan output word
- emu_ram_se  in  1  RAM scan enable
- emu_ram_sd  in  1  RAM scan direction: 0 = dump, 1 = load
- emu_ram_di  in  64  RAM load word
- emu_ram_do  out  64  RAM dump word
- raddr  in  3  read address
- rdata  out  80  registered read data
- wen  in  1  write enable
- waddr  in  3  write address
- wdata  in  80  write data

Behaviour:
- Reset (async, active-low):
  - rdata register = 0, FF chain = 0, emu_ram_do = 0, scan counter = 0.
  - Memory array is not reset.
- FF domain updates only on edges with emu_ff_clk_en=1.
  - ff_se=0: rdata <= mem[raddr]. One-cycle latency. Read-first: if a write hits the same address on the same edge, rdata returns the old data.
  - ff_se=1: chain shifts instead of functional update.
  - Chain word0 = rdata[63:0]; word1 = {48'b0, rdata[79:64]}.
  - emu_ff_do = word0, combinational from the register.
  - Each shift: word0 <= word1, word1 <= emu_ff_di. Pad bits are ignored on load.
  - Two shifts with do looped to di restore the original contents; two shifts of saved word0 then word1 load them.
- RAM domain updates only on edges with emu_ram_clk_en=1.
  - ram_se=0: mem[waddr] <= wdata when wen=1.
  - ram_se=1: functional writes are suppressed. RAM scan never touches the rdata register.
- Scan counter:
  - Cleared synchronously on any edge with emu_ram_se=0, independent of the enable.
  - Increments once per enabled edge with ram_se=1.
  - Saturates after MEM_WORDS+1; further words are ignored.
  - Word k maps to entry k/2: k even = bits [63:0], k odd = {48'b0, bits[79:64]}.
- Dump (sd=0):
  - emu_ram_do is registered.
  - Word j is valid after the (j+2)th enabled edge with se=1: two-cycle start latency, then one word per cycle.
  - Memory is unchanged.
- Load (sd=1):
  - emu_ram_di is word j on the (j+1)th enabled edge with se=1.
  - Even words are held in a low-half buffer. The odd word writes the full 80-bit entry.
  - Extra edges beyond MEM_WORDS do nothing.
- Edge cases:
  - Direction change mid-scan: behaviour is undefined. The host must drop se first.
  - Reset mid-scan: clears the counter; partial load buffer is discarded.

Decomposition:
- Package emu_scan_pkg holds:
  - DATA_WIDTH, ADDR_WIDTH, SCAN_WIDTH;
  - derived FF_WORDS and MEM_WORDS;
  - scan word typedef.
- One natural sub-module, emu_ram_scan_ctrl: counter, word/half mapping, load buffer, dump output register.

Test Plan:
- Write mem[0..7] with random 80-bit values, then raddr=1 for one cycle -> rdata == mem[1] on the next cycle.
- Pause (both enables low) 1 cycle, then ff_se=1 with do looped to di for 2 cycles -> ff_do is rdata[63:0] then {48'b0, rdata[79:64]}; rdata unchanged afterwards.
- Pause, ram_se=1 sd=0 -> after 2 cycles, 16 consecutive words equal mem[0] lo, mem[0] hi, ... mem[7] hi.
- Four rounds of the above with different random data saved, then overwrite everything.
- Per round, restore: ff load of 2 saved words, then ram load (sd=1) of 16 words plus 1 extra cycle, then unpause -> rdata equals the saved value, and reading raddr 0..7 returns that round's data.
- wen=1, waddr=raddr=3, new wdata -> rdata shows the old mem[3] that cycle and the new value the next cycle.
- Assert reset mid ram dump -> counter cleared, rdata = 0, memory contents preserved.
